// File: rtl/vga_rect_fill_engine.sv
// Rectangle fill engine: orders and clips corners, then emits one raster-order pixel write per clock.
// Optional power-up frame clear is enabled with `define VGA_RECT_CLEAR_ON_RESET_EN.
module vga_rect_fill_engine #(
    parameter int              FB_WIDTH    = 160,
    parameter int              FB_HEIGHT   = 120,
    parameter int              COLOR_BITS  = 9,
    parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = '0
) (
    input  logic                  Slow_Clock,
    input  logic                  Reset_N,
    input  logic                  Cmd_Valid,
    output logic                  Cmd_Ready,
    input  logic [7:0]            Cmd_X0,
    input  logic [7:0]            Cmd_X1,
    input  logic [7:0]            Cmd_Y0,
    input  logic [7:0]            Cmd_Y1,
    input  logic [COLOR_BITS-1:0] Cmd_Color,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Enable_Draw,
    output logic [31:0]           Draw_X,
    output logic [31:0]           Draw_Y,
    output logic [31:0]           Draw_Color
);

    localparam logic [7:0] XMAX = 8'(FB_WIDTH - 1);
    localparam logic [7:0] YMAX = 8'(FB_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_FILL,
        S_CLEAR
    } state_t;

    state_t state, state_nx;

    logic [7:0]            lx0, lx1, ly0, ly1;
    logic [COLOR_BITS-1:0] lcol;
    logic [7:0]            xs, xe, ye;
    logic [7:0]            cx, cy;
    logic [COLOR_BITS-1:0] fill_color;
    logic                  done_q;

    logic [7:0] xlo, xhi, ylo, yhi, xhi_c, yhi_c;
    logic       empty, last, fire;

`ifdef VGA_RECT_CLEAR_ON_RESET_EN
    logic clr_pend;
`else
    logic unused_clear;
    assign unused_clear = ^CLEAR_COLOR;
`endif

    // Corner ordering, clipping and end-of-rectangle detection.
    always_comb begin
        xlo   = (lx0 < lx1) ? lx0 : lx1;
        xhi   = (lx0 < lx1) ? lx1 : lx0;
        ylo   = (ly0 < ly1) ? ly0 : ly1;
        yhi   = (ly0 < ly1) ? ly1 : ly0;
        xhi_c = (xhi > XMAX) ? XMAX : xhi;
        yhi_c = (yhi > YMAX) ? YMAX : yhi;
        empty = (xlo > XMAX) || (ylo > YMAX);
        last  = (cx == xe) && (cy == ye);
        fire  = Cmd_Valid && Cmd_Ready;
    end

    // State register.
    always_ff @(posedge Slow_Clock) begin
        if (!Reset_N) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
`ifdef VGA_RECT_CLEAR_ON_RESET_EN
                if (clr_pend)  state_nx = S_CLEAR;
                else
`endif
                if (fire)      state_nx = S_SETUP;
            end
            S_SETUP: state_nx = empty ? S_IDLE : S_FILL;
            S_FILL:  if (last) state_nx = S_IDLE;
            S_CLEAR: if (last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake and strobe outputs decoded from state.
    always_comb begin
`ifdef VGA_RECT_CLEAR_ON_RESET_EN
        Cmd_Ready   = (state == S_IDLE) && !clr_pend;
`else
        Cmd_Ready   = (state == S_IDLE);
`endif
        Busy        = (state != S_IDLE);
        Enable_Draw = (state == S_FILL) || (state == S_CLEAR);
        Done        = done_q;
        Draw_X      = {24'd0, cx};
        Draw_Y      = {24'd0, cy};
        Draw_Color  = {{(32-COLOR_BITS){1'b0}}, fill_color};
    end

    // Command latch, raster counters and completion pulse.
    always_ff @(posedge Slow_Clock) begin
        if (!Reset_N) begin
            lx0        <= '0;
            lx1        <= '0;
            ly0        <= '0;
            ly1        <= '0;
            lcol       <= '0;
            xs         <= '0;
            xe         <= '0;
            ye         <= '0;
            cx         <= '0;
            cy         <= '0;
            fill_color <= '0;
            done_q     <= 1'b0;
`ifdef VGA_RECT_CLEAR_ON_RESET_EN
            clr_pend   <= 1'b1;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
`ifdef VGA_RECT_CLEAR_ON_RESET_EN
                    if (clr_pend) begin
                        clr_pend   <= 1'b0;
                        xs         <= '0;
                        xe         <= XMAX;
                        ye         <= YMAX;
                        cx         <= '0;
                        cy         <= '0;
                        fill_color <= CLEAR_COLOR;
                    end else
`endif
                    if (fire) begin
                        lx0  <= Cmd_X0;
                        lx1  <= Cmd_X1;
                        ly0  <= Cmd_Y0;
                        ly1  <= Cmd_Y1;
                        lcol <= Cmd_Color;
                    end
                end
                S_SETUP: begin
                    if (empty) begin
                        done_q <= 1'b1;
                    end else begin
                        xs         <= xlo;
                        xe         <= xhi_c;
                        ye         <= yhi_c;
                        cx         <= xlo;
                        cy         <= ylo;
                        fill_color <= lcol;
                    end
                end
                S_FILL, S_CLEAR: begin
                    if (last) begin
                        done_q <= 1'b1;
                    end else if (cx == xe) begin
                        cx <= xs;
                        cy <= cy + 8'd1;
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_fill_engine.sv
// Directed testbench for vga_rect_fill_engine (default build, no power-up clear).
// Inputs change on negedge; outputs are sampled on negedge.
module tb_vga_rect_fill_engine;

    logic        Slow_Clock = 1'b0;
    logic        Reset_N;
    logic        Cmd_Valid;
    logic        Cmd_Ready;
    logic [7:0]  Cmd_X0, Cmd_X1, Cmd_Y0, Cmd_Y1;
    logic [8:0]  Cmd_Color;
    logic        Busy, Done, Enable_Draw;
    logic [31:0] Draw_X, Draw_Y, Draw_Color;

    vga_rect_fill_engine dut (
        .Slow_Clock  (Slow_Clock),
        .Reset_N     (Reset_N),
        .Cmd_Valid   (Cmd_Valid),
        .Cmd_Ready   (Cmd_Ready),
        .Cmd_X0      (Cmd_X0),
        .Cmd_X1      (Cmd_X1),
        .Cmd_Y0      (Cmd_Y0),
        .Cmd_Y1      (Cmd_Y1),
        .Cmd_Color   (Cmd_Color),
        .Busy        (Busy),
        .Done        (Done),
        .Enable_Draw (Enable_Draw),
        .Draw_X      (Draw_X),
        .Draw_Y      (Draw_Y),
        .Draw_Color  (Draw_Color)
    );

    always #5 Slow_Clock = ~Slow_Clock;

    int errors = 0;
    int checks = 0;

    int   nw, ndone, nacc, bad_coord, done_after;
    int   wx [0:255];
    int   wy [0:255];
    int   wc [0:255];
    int   wt [0:255];
    int   dcyc [0:3];
    int   acc [0:3];
    logic bz [0:255];
    logic rd [0:255];
    int   hx, hy, hc;

    // Records per-cycle activity; cycle 0 is the negedge before the handshake posedge.
    task automatic capture(input int want_done, input int limit, input int c0);
        nw = 0; ndone = 0; nacc = 0; bad_coord = 0; done_after = -1;
        hx = -1; hy = -1; hc = -1;
        for (int c = c0; c <= limit; c++) begin
            if (c > 0) @(negedge Slow_Clock);
            bz[c] = Busy;
            rd[c] = Cmd_Ready;
            if (Enable_Draw) begin
                if (nw < 256) begin
                    wx[nw] = int'(Draw_X);
                    wy[nw] = int'(Draw_Y);
                    wc[nw] = int'(Draw_Color);
                    wt[nw] = c;
                end
                if (Draw_X >= 160 || Draw_Y >= 120) bad_coord++;
                nw++;
            end
            if (Done && ndone < 4) begin
                dcyc[ndone] = c;
                ndone++;
            end
            if (Cmd_Valid && Cmd_Ready) begin
                if (nacc < 4) acc[nacc] = c;
                nacc++;
            end else if (nacc > 0 && c == acc[nacc-1] + 1) begin
                Cmd_Valid = 1'b0;
            end
            if (ndone == want_done) begin
                hx = int'(Draw_X);
                hy = int'(Draw_Y);
                hc = int'(Draw_Color);
                @(negedge Slow_Clock);
                done_after = int'(Done);
                break;
            end
        end
        Cmd_Valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1,
                           input logic [8:0] col);
        @(negedge Slow_Clock);
        Cmd_X0 = x0; Cmd_Y0 = y0; Cmd_X1 = x1; Cmd_Y1 = y1;
        Cmd_Color = col;
        Cmd_Valid = 1'b1;
        capture(1, 200, 0);
    endtask

    task automatic test_reset;
        Reset_N = 1'b0;
        Cmd_Valid = 1'b0;
        Cmd_X0 = 8'd0; Cmd_X1 = 8'd0; Cmd_Y0 = 8'd0; Cmd_Y1 = 8'd0;
        Cmd_Color = 9'd0;
        repeat (2) @(negedge Slow_Clock);
        checks++;
        if (Cmd_Ready !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 || Enable_Draw !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b busy=%b done=%b en=%b, required 1 0 0 0",
                     Cmd_Ready, Busy, Done, Enable_Draw);
        end
        checks++;
        if (Draw_X !== 32'd0 || Draw_Y !== 32'd0 || Draw_Color !== 32'd0) begin
            errors++;
            $display("FAIL reset_draw: x=%0h y=%0h c=%0h, required 0 0 0", Draw_X, Draw_Y, Draw_Color);
        end
        Reset_N = 1'b1;
        @(negedge Slow_Clock);
        checks++;
        if (Cmd_Ready !== 1'b1 || Enable_Draw !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ready=%b en=%b, required 1 0", Cmd_Ready, Enable_Draw);
        end
    endtask

    task automatic test_basic(input logic [7:0] x0, input logic [7:0] y0,
                              input logic [7:0] x1, input logic [7:0] y1,
                              input logic [8:0] col, input string nm);
        int ex [0:5];
        int ey [0:5];
        ex = '{2, 3, 4, 2, 3, 4};
        ey = '{3, 3, 3, 4, 4, 4};
        run_cmd(x0, y0, x1, y1, col);
        checks++;
        if (nacc != 1 || acc[0] != 0) begin
            errors++;
            $display("FAIL %s_accept: nacc=%0d cyc=%0d, required 1 0", nm, nacc, acc[0]);
        end
        checks++;
        if (nw != 6) begin
            errors++;
            $display("FAIL %s_count: writes=%0d, required 6", nm, nw);
        end
        for (int i = 0; i < 6 && i < nw; i++) begin
            checks++;
            if (wx[i] != ex[i] || wy[i] != ey[i] || wc[i] != int'(col) || wt[i] != 2 + i) begin
                errors++;
                $display("FAIL %s_pix%0d: (%0d,%0d) c=%0h t=%0d, required (%0d,%0d) c=%0h t=%0d",
                         nm, i, wx[i], wy[i], wc[i], wt[i], ex[i], ey[i], col, 2 + i);
            end
        end
        checks++;
        if (ndone != 1 || dcyc[0] != 8 || done_after != 0) begin
            errors++;
            $display("FAIL %s_done: n=%0d cyc=%0d after=%0d, required 1 8 0",
                     nm, ndone, dcyc[0], done_after);
        end
        checks++;
        if (bz[1] !== 1'b1 || bz[7] !== 1'b1 || bz[8] !== 1'b0 || rd[8] !== 1'b1 || rd[1] !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: b1=%b b7=%b b8=%b r1=%b r8=%b, required 1 1 0 0 1",
                     nm, bz[1], bz[7], bz[8], rd[1], rd[8]);
        end
        checks++;
        if (hx != 4 || hy != 4 || hc != int'(col)) begin
            errors++;
            $display("FAIL %s_hold: (%0d,%0d) c=%0h, required (4,4) c=%0h", nm, hx, hy, hc, col);
        end
    endtask

    task automatic test_clip;
        int ex [0:3];
        int ey [0:3];
        ex = '{158, 159, 158, 159};
        ey = '{118, 118, 119, 119};
        run_cmd(8'd158, 8'd118, 8'd200, 8'd255, 9'h1FF);
        checks++;
        if (nw != 4 || bad_coord != 0) begin
            errors++;
            $display("FAIL clip_count: writes=%0d out_of_range=%0d, required 4 0", nw, bad_coord);
        end
        for (int i = 0; i < 4 && i < nw; i++) begin
            checks++;
            if (wx[i] != ex[i] || wy[i] != ey[i] || wt[i] != 2 + i) begin
                errors++;
                $display("FAIL clip_pix%0d: (%0d,%0d) t=%0d, required (%0d,%0d) t=%0d",
                         i, wx[i], wy[i], wt[i], ex[i], ey[i], 2 + i);
            end
        end
        checks++;
        if (ndone != 1 || dcyc[0] != 6) begin
            errors++;
            $display("FAIL clip_done: n=%0d cyc=%0d, required 1 6", ndone, dcyc[0]);
        end
    endtask

    task automatic test_empty;
        run_cmd(8'd170, 8'd0, 8'd180, 8'd5, 9'h111);
        checks++;
        if (nw != 0) begin
            errors++;
            $display("FAIL empty_count: writes=%0d, required 0", nw);
        end
        checks++;
        if (ndone != 1 || dcyc[0] != 2 || done_after != 0) begin
            errors++;
            $display("FAIL empty_done: n=%0d cyc=%0d after=%0d, required 1 2 0",
                     ndone, dcyc[0], done_after);
        end
        checks++;
        if (hx != 159 || hy != 119 || hc != 32'h1FF) begin
            errors++;
            $display("FAIL empty_hold: (%0d,%0d) c=%0h, required (159,119) c=1ff", hx, hy, hc);
        end
    endtask

    task automatic test_back_to_back;
        int ex [0:3];
        int ey [0:3];
        int ec [0:3];
        int et [0:3];
        ex = '{0, 1, 5, 5};
        ey = '{0, 0, 5, 6};
        ec = '{32'h0AA, 32'h0AA, 32'h155, 32'h155};
        et = '{2, 3, 6, 7};
        @(negedge Slow_Clock);
        Cmd_X0 = 8'd0; Cmd_Y0 = 8'd0; Cmd_X1 = 8'd1; Cmd_Y1 = 8'd0;
        Cmd_Color = 9'h0AA;
        Cmd_Valid = 1'b1;
        @(posedge Slow_Clock);
        #1;
        Cmd_X0 = 8'd5; Cmd_Y0 = 8'd6; Cmd_X1 = 8'd5; Cmd_Y1 = 8'd5;
        Cmd_Color = 9'h155;
        capture(2, 200, 1);
        checks++;
        if (nacc != 1 || acc[0] != 4) begin
            errors++;
            $display("FAIL b2b_accept: nacc=%0d cyc=%0d, required 1 4", nacc, acc[0]);
        end
        checks++;
        if (nw != 4) begin
            errors++;
            $display("FAIL b2b_count: writes=%0d, required 4", nw);
        end
        for (int i = 0; i < 4 && i < nw; i++) begin
            checks++;
            if (wx[i] != ex[i] || wy[i] != ey[i] || wc[i] != ec[i] || wt[i] != et[i]) begin
                errors++;
                $display("FAIL b2b_pix%0d: (%0d,%0d) c=%0h t=%0d, required (%0d,%0d) c=%0h t=%0d",
                         i, wx[i], wy[i], wc[i], wt[i], ex[i], ey[i], ec[i], et[i]);
            end
        end
        checks++;
        if (ndone != 2 || dcyc[0] != 4 || dcyc[1] != 8) begin
            errors++;
            $display("FAIL b2b_done: n=%0d c0=%0d c1=%0d, required 2 4 8", ndone, dcyc[0], dcyc[1]);
        end
    endtask

    task automatic test_reset_mid_fill;
        int seen;
        int late;
        seen = 0;
        @(negedge Slow_Clock);
        Cmd_X0 = 8'd0; Cmd_Y0 = 8'd0; Cmd_X1 = 8'd9; Cmd_Y1 = 8'd9;
        Cmd_Color = 9'h0F0;
        Cmd_Valid = 1'b1;
        @(posedge Slow_Clock);
        #1 Cmd_Valid = 1'b0;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            @(negedge Slow_Clock);
            if (Enable_Draw) seen++;
        end
        checks++;
        if (seen != 3) begin
            errors++;
            $display("FAIL rst_fill_start: writes=%0d, required 3", seen);
        end
        Reset_N = 1'b0;
        @(negedge Slow_Clock);
        checks++;
        if (Enable_Draw !== 1'b0 || Cmd_Ready !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: en=%b ready=%b busy=%b done=%b, required 0 1 0 0",
                     Enable_Draw, Cmd_Ready, Busy, Done);
        end
        checks++;
        if (Draw_X !== 32'd0 || Draw_Y !== 32'd0 || Draw_Color !== 32'd0) begin
            errors++;
            $display("FAIL rst_abort_draw: x=%0h y=%0h c=%0h, required 0 0 0", Draw_X, Draw_Y, Draw_Color);
        end
        Reset_N = 1'b1;
        late = 0;
        repeat (6) begin
            @(negedge Slow_Clock);
            if (Enable_Draw || Done) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL rst_quiet: active_cycles=%0d, required 0", late);
        end
        run_cmd(8'd7, 8'd7, 8'd7, 8'd7, 9'h033);
        checks++;
        if (nw != 1 || wx[0] != 7 || wy[0] != 7 || wc[0] != 32'h033 || dcyc[0] != 3) begin
            errors++;
            $display("FAIL rst_recover: writes=%0d (%0d,%0d) c=%0h done=%0d, required 1 (7,7) c=33 done=3",
                     nw, wx[0], wy[0], wc[0], dcyc[0]);
        end
    endtask

    initial begin
        test_reset;
        test_basic(8'd2, 8'd3, 8'd4, 8'd4, 9'h1C7, "basic");
        test_basic(8'd4, 8'd4, 8'd2, 8'd3, 9'h0F0, "swap");
        test_clip;
        test_empty;
        test_back_to_back;
        test_reset_mid_fill;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
